// File: rtl/pci_arbiter_if.sv
// Shared PCI arbitration signals: active-low request/grant plus monitored FRAME/IRDY.
// slave = arbiter side, master = bus agents side.
interface pci_arbiter_if;
    logic [3:0] request;
    logic       iframe;
    logic       iready;
    logic [3:0] grant;
    logic [1:0] bus_owner;
    logic       owner_valid;

    modport slave (
        input  request, iframe, iready,
        output grant, bus_owner, owner_valid
    );

    modport master (
        output request, iframe, iready,
        input  grant, bus_owner, owner_valid
    );
endinterface

// File: rtl/pci_arbiter.sv
// Purpose: 4-master round-robin PCI bus arbiter; optional grant timeout under PCI_ARB_TIMEOUT_EN.
// Latency: grant issued one clk edge after a request is seen in IDLE; release costs one TURN cycle.
// Backpressure: a granted master keeps the bus while FRAME/IRDY are active; new requests wait for IDLE.
module pci_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    pci_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] grant_q, grant_nxt;
    logic [1:0] owner_q, owner_nxt;
    logic [1:0] ptr_q, ptr_nxt;
    logic [1:0] winner, cand;
    logic       any_req;
    logic       frame_act, irdy_act, owner_req;
    logic       timed_out;

    // Only a clean logic 0 counts as asserted; X/Z on the shared bus reads as idle.
    always_comb begin
        frame_act = 1'b0;
        irdy_act  = 1'b0;
        owner_req = 1'b0;
        if (bus.iframe == 1'b0)           frame_act = 1'b1;
        if (bus.iready == 1'b0)           irdy_act  = 1'b1;
        if (bus.request[owner_q] == 1'b0) owner_req = 1'b1;
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        any_req = 1'b0;
        winner  = ptr_q;
        cand    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.request[cand] == 1'b0) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

`ifdef PCI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_nxt;

    assign timed_out = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_nxt = cnt_q;
        if (state == IDLE && any_req)
            cnt_nxt = '0;
        else if (state == GRANT)
            cnt_nxt = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_nxt;
    end
`else
    // GRANT never times out in this build; the parameter stays referenced for a uniform interface.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        owner_nxt = owner_q;
        ptr_nxt   = ptr_q;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = ~(4'b0001 << winner);
                    owner_nxt = winner;
                    ptr_nxt   = winner + 2'd1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (frame_act) begin
                    state_nxt = BUSY;
                end else if (!owner_req || timed_out) begin
                    grant_nxt = 4'b1111;
                    state_nxt = TURN;
                end
            end
            BUSY: begin
                if (!frame_act && !irdy_act) begin
                    grant_nxt = 4'b1111;
                    state_nxt = TURN;
                end
            end
            TURN: begin
                grant_nxt = 4'b1111;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 4'b1111;
                state_nxt = IDLE;
            end
        endcase
    end

    // Async reset drops every grant the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= 4'b1111;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            owner_q <= owner_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.bus_owner   = owner_q;
    assign bus.owner_valid = ~&grant_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: vector table, directed corner sequences, randomized run vs model.
module tb_pci_arbiter;

    localparam int TO = 16;

    logic clk;
    logic reset;
    pci_arbiter_if bus_if ();

    pci_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current owner (-1 = none), last owner, priority pointer,
    // a pending one-cycle turnaround, transfer-started flag and grant-wait counter.
    int m_owner, m_last, m_ptr, m_wait;
    bit m_turn, m_busy;

    typedef struct {
        logic [3:0] req;
        logic       fr;
        logic       ir;
        logic [3:0] g;
        logic [1:0] own;
        logic       v;
    } vec_t;

    vec_t tbl [19];

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [3:0] g);
        for (int k = 0; k < 4; k++)
            if (g[k] === 1'b0) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_wait = 0;
        m_turn = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_release();
        m_owner = -1; m_turn = 1'b1; m_busy = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        int c;
        if (m_owner < 0) begin
            if (m_turn) begin
                m_turn = 1'b0;
            end else begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (!found && bus_if.request[c] === 1'b0) begin
                        found = 1'b1;
                        m_owner = c; m_last = c; m_ptr = (c + 1) % 4;
                        m_busy = 1'b0; m_wait = 0;
                    end
                end
            end
        end else if (!m_busy) begin
            if (bus_if.iframe === 1'b0) m_busy = 1'b1;
            else if (bus_if.request[m_owner] !== 1'b0) model_release();
            else begin
                m_wait++;
`ifdef PCI_ARB_TIMEOUT_EN
                if (m_wait == TO) model_release();
`endif
            end
        end else if (bus_if.iframe !== 1'b0 && bus_if.iready !== 1'b0) begin
            model_release();
        end
    endtask

    task automatic tick();
        logic [3:0] eg;
        logic [1:0] eo;
        @(posedge clk);
        #1;
        model_step();
        eg = 4'b1111;
        if (m_owner >= 0) eg[m_owner] = 1'b0;
        eo = m_last[1:0];
        chk4("mdl_grant", bus_if.grant, eg);
        chk4("mdl_owner", {2'b00, bus_if.bus_owner}, {2'b00, eo});
        chk4("mdl_valid", {3'b000, bus_if.owner_valid}, {3'b000, (m_owner >= 0)});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.request = 4'b1111;
        bus_if.iframe  = 1'b1;
        bus_if.iready  = 1'b1;
        @(posedge clk);
        #1;
        chk4("rst_grant", bus_if.grant, 4'b1111);
        chk4("rst_owner", {2'b00, bus_if.bus_owner}, 4'd0);
        chk4("rst_valid", {3'b000, bus_if.owner_valid}, 4'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [$];
        int gaps [$];
        int gap, left, held;
        logic [3:0] prev;

        tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
        tbl[1]  = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1};
        tbl[2]  = '{4'b1110, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1};
        tbl[3]  = '{4'b1111, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b1};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
        tbl[6]  = '{4'b0000, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1};
        tbl[8]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0};
        tbl[9]  = '{4'b0110, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0};
        tbl[10] = '{4'b0110, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1};
        tbl[11] = '{4'b1110, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0};
        tbl[12] = '{4'b1110, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0};
        tbl[13] = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1};
        tbl[14] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
        tbl[15] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
        tbl[16] = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1};
        tbl[17] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
        tbl[18] = '{4'b1111, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            bus_if.request = tbl[i].req;
            bus_if.iframe  = tbl[i].fr;
            bus_if.iready  = tbl[i].ir;
            tick();
            chk4($sformatf("tbl%0d_grant", i), bus_if.grant, tbl[i].g);
            chk4($sformatf("tbl%0d_owner", i), {2'b00, bus_if.bus_owner}, {2'b00, tbl[i].own});
            chk4($sformatf("tbl%0d_valid", i), {3'b000, bus_if.owner_valid}, {3'b000, tbl[i].v});
        end

        // All four masters requesting, each runs a 3-cycle FRAME transaction.
        do_reset();
        bus_if.request = 4'b0000;
        gap = 0; left = 0; prev = 4'b1111;
        for (int cyc = 0; cyc < 200 && order.size() < 5; cyc++) begin
            tick();
            if (bus_if.grant != 4'b1111) begin
                if (prev == 4'b1111) begin
                    order.push_back(dec(bus_if.grant));
                    gaps.push_back(gap);
                    gap = 0;
                    left = 3;
                end
            end else begin
                gap++;
            end
            if (bus_if.grant != 4'b1111 && left > 0) begin
                bus_if.iframe = 1'b0;
                left--;
            end else begin
                bus_if.iframe = 1'b1;
            end
            prev = bus_if.grant;
        end
        chk_int("rr_count", order.size(), 5);
        for (int i = 0; i < order.size(); i++) begin
            chk_int($sformatf("rr_order%0d", i), order[i], i % 4);
            if (i > 0) chk_int($sformatf("rr_gap%0d_nonzero", i), int'(gaps[i] >= 1), 1);
        end

        // Owner withdraws request mid-transfer: grant held until FRAME and IRDY both idle.
        do_reset();
        bus_if.request = 4'b1011;
        tick();
        chk4("busy_issue", bus_if.grant, 4'b1011);
        bus_if.iframe = 1'b0;
        tick();
        chk4("busy_c1", bus_if.grant, 4'b1011);
        bus_if.request = 4'b1111;
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk4($sformatf("busy_c%0d", i), bus_if.grant, 4'b1011);
        end
        bus_if.iframe = 1'b1;
        bus_if.iready = 1'b0;
        tick();
        chk4("busy_irdy_hold", bus_if.grant, 4'b1011);
        bus_if.iready = 1'b1;
        tick();
        chk4("busy_release", bus_if.grant, 4'b1111);
        tick();
        chk4("busy_turn_idle", bus_if.grant, 4'b1111);

        // Master 1 granted but never starts; master 2 also waiting.
        do_reset();
        bus_if.request = 4'b1001;
        tick();
        chk4("stall_issue", bus_if.grant, 4'b1101);
        held = 1;
`ifdef PCI_ARB_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.grant == 4'b1101) held++;
            else break;
        end
        chk_int("timeout_cycles", held, TO);
        chk4("timeout_release", bus_if.grant, 4'b1111);
        tick();
        chk4("timeout_turn", bus_if.grant, 4'b1111);
        tick();
        chk4("timeout_next_owner", bus_if.grant, 4'b1011);
`else
        for (int i = 0; i < 99; i++) begin
            tick();
            if (bus_if.grant == 4'b1101) held++;
        end
        chk_int("no_timeout_hold", held, 100);
`endif

        // Reset pulse during BUSY drops the grant without a clock edge.
        do_reset();
        bus_if.request = 4'b1101;
        tick();
        bus_if.iframe = 1'b0;
        tick();
        chk4("pre_rst_busy", bus_if.grant, 4'b1101);
        #2;
        reset = 1'b1;
        #1;
        chk4("async_rst_grant", bus_if.grant, 4'b1111);
        chk4("async_rst_owner", {2'b00, bus_if.bus_owner}, 4'd0);
        chk4("async_rst_valid", {3'b000, bus_if.owner_valid}, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_if.request = 4'b0011;
        bus_if.iframe  = 1'b1;
        bus_if.iready  = 1'b1;
        model_reset();
        tick();
        chk4("post_rst_grant", bus_if.grant, 4'b1011);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) bus_if.request = 4'($urandom_range(0, 15));
            bus_if.iframe = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            bus_if.iready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
